// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state encoding and
// the owner tag that remembers which requester an in-flight transaction
// belongs to.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the memory arbiter. Data normally wins over fetch.
// A saturating counter tracks how many IDLE arbitrations fetch has lost in a
// row; once it reaches MAX_WAIT, fetch wins the next contested arbitration.
module arb_pick #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic state_is_idle,
    input  logic if_valid,
    input  logic d_valid,
    output logic grant_if,
    output logic grant_d
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_waitCnt;
    logic          w_forceIf;

    // Fetch takes priority only once it has been starved MAX_WAIT times
    always_comb begin
        w_forceIf = (r_waitCnt == CW'(MAX_WAIT));
        grant_d   = state_is_idle && d_valid && !(if_valid && w_forceIf);
        grant_if  = state_is_idle && if_valid && !grant_d;
    end

    // Count lost fetch arbitrations, clear when fetch is finally served
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_waitCnt <= '0;
        end else if (grant_if) begin
            r_waitCnt <= '0;
        end else if (grant_d && if_valid && !w_forceIf) begin
            r_waitCnt <= r_waitCnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Unified memory-port arbiter between instruction fetch and data load/store.
// One transaction is in flight at a time: accept in IDLE, present the latched
// request in REQ until memory takes it, then wait in RSP for the response,
// which is steered combinationally back to whichever requester owns it.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [AW-1:0]   if_req_addr,
    output logic            if_rsp_valid,
    output logic [DW-1:0]   if_rsp_data,

    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [AW-1:0]   d_req_addr,
    input  logic            d_req_wen,
    input  logic [DW/8-1:0] d_req_wstrb,
    input  logic [DW-1:0]   d_req_wdata,
    output logic            d_rsp_valid,
    output logic [DW-1:0]   d_rsp_data,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_wen,
    output logic [DW/8-1:0] mem_req_wstrb,
    output logic [DW-1:0]   mem_req_wdata,
    input  logic            mem_rsp_valid,
    input  logic [DW-1:0]   mem_rsp_data,

    output logic            busy
);

    arb_state_t      r_state;
    logic            r_owner;
    logic [AW-1:0]   r_addr;
    logic            r_wen;
    logic [DW/8-1:0] r_wstrb;
    logic [DW-1:0]   r_wdata;
    logic            r_memReqValid;

    logic            w_idle;
    logic            w_grantIf;
    logic            w_grantD;
    logic            w_rspFire;

    // Arbitration is only offered in IDLE and never while reset is asserted
    assign w_idle = (r_state == ARB_IDLE) && rst;

    arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .clk           (clk),
        .rst           (rst),
        .state_is_idle (w_idle),
        .if_valid      (if_req_valid),
        .d_valid       (d_req_valid),
        .grant_if      (w_grantIf),
        .grant_d       (w_grantD)
    );

    // Ready strobes, memory request view and response steering
    always_comb begin
        if_req_ready  = w_grantIf;
        d_req_ready   = w_grantD;
        mem_req_valid = r_memReqValid;
        mem_req_addr  = r_addr;
        mem_req_wen   = r_wen;
        mem_req_wstrb = r_wstrb;
        mem_req_wdata = r_wdata;
        busy          = (r_state != ARB_IDLE);
        w_rspFire     = (r_state == ARB_RSP) && mem_rsp_valid && rst;
        if_rsp_valid  = w_rspFire && (r_owner == OWN_IF);
        d_rsp_valid   = w_rspFire && (r_owner == OWN_D);
        if_rsp_data   = if_rsp_valid ? mem_rsp_data : '0;
        d_rsp_data    = d_rsp_valid  ? mem_rsp_data : '0;
    end

    // Transaction FSM: latch the winner's request, hand it to memory, await reply
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ARB_IDLE;
            r_owner       <= OWN_IF;
            r_addr        <= '0;
            r_wen         <= 1'b0;
            r_wstrb       <= '0;
            r_wdata       <= '0;
            r_memReqValid <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grantD) begin
                        r_owner       <= OWN_D;
                        r_addr        <= d_req_addr;
                        r_wen         <= d_req_wen;
                        r_wstrb       <= d_req_wstrb;
                        r_wdata       <= d_req_wdata;
                        r_memReqValid <= 1'b1;
                        r_state       <= ARB_REQ;
                    end else if (w_grantIf) begin
                        r_owner       <= OWN_IF;
                        r_addr        <= if_req_addr;
                        r_wen         <= 1'b0;
                        r_wstrb       <= '0;
                        r_wdata       <= '0;
                        r_memReqValid <= 1'b1;
                        r_state       <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (mem_req_ready) begin
                        r_memReqValid <= 1'b0;
                        r_state       <= ARB_RSP;
                    end
                end
                ARB_RSP: begin
                    if (mem_rsp_valid) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: begin
                    r_memReqValid <= 1'b0;
                    r_state       <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates a single unified memory port between instruction fetch (IF) and data load/store (D) requesters of the single-cycle core.
- Provides the path that lets the core return real load data instead of zero.
- Handles one outstanding transaction at a time.
- Priority is fixed, data over fetch, with a starvation guard for fetch.
- Responses are routed back to the owner of the transaction.

Parameters:
- AW, 32: address width.
- DW, 32: data width; DW/8 write-strobe bits.
- MAX_WAIT, 4: number of consecutive lost IDLE arbitrations after which IF wins.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (one clock; rst low at a clk rising edge resets the block)
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  AW  fetch address
- if_rsp_valid  out  1  fetch response strobe
- if_rsp_data  out  DW  fetch data
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_addr  in  AW  data address
- d_req_wen  in  1  1 = store, 0 = load
- d_req_wstrb  in  DW/8  byte enables for a store
- d_req_wdata  in  DW  store data
- d_rsp_valid  out  1  data response strobe (load data or store ack)
- d_rsp_data  out  DW  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  AW  latched address
- mem_req_wen  out  1  latched write enable
- mem_req_wstrb  out  DW/8  latched strobes
- mem_req_wdata  out  DW  latched write data
- mem_rsp_valid  in  1  memory response (also the store ack)
- mem_rsp_data  in  DW  memory read data
- busy  out  1  state != ARB_IDLE

Behaviour:
- Reset (rst low at a clk edge):
  - state = ARB_IDLE.
  - Owner = IF; fetch wait counter = 0.
  - All latched request registers = 0.
  - Every valid/ready output reads 0 in the cycle after the edge; busy = 0.
- Reset mid-transaction: the transaction is abandoned and no response strobe is issued; memory is reset alongside.
- State machine, states ARB_IDLE, ARB_REQ, ARB_RSP:
  - ARB_IDLE: if any request valid, pick a winner and assert that requester's *_req_ready combinationally (never both).
    - Latch addr/wen/wstrb/wdata and the owner.
    - IF requests latch wen=0 and wstrb=0.
    - Go to ARB_REQ.
  - ARB_REQ: mem_req_valid=1 with the latched fields, which hold stable. On mem_req_ready go to ARB_RSP.
  - ARB_RSP: wait for mem_rsp_valid.
    - In that cycle, owner's *_rsp_valid = 1 and *_rsp_data = mem_rsp_data, combinationally.
    - Go to ARB_IDLE. The next accept happens no earlier than the following cycle.
- Latency and throughput:
  - Minimum 3 cycles per transaction: accept, request, response.
  - With zero-wait memory: accept at cycle N, response strobe at N+2.
- Priority:
  - Default: D wins when both are valid.
  - The wait counter increments (saturating at MAX_WAIT) in each ARB_IDLE cycle in which if_req_valid=1 and D is granted.
  - The counter clears when IF is granted.
  - When counter == MAX_WAIT and both are valid, IF wins.
  - The counter is unchanged when if_req_valid=0. Counter width is $clog2(MAX_WAIT+1).
- Requesters must hold valid and their fields until ready. Dropping valid before ready is allowed and grants nothing.
- mem_rsp_valid outside ARB_RSP is ignored. Memory must not respond in the same cycle as mem_req_ready.
- *_rsp_data reads 0 whenever its rsp_valid is 0.
- Stores complete only on mem_rsp_valid. d_rsp_valid pulses for stores too; d_rsp_data then passes mem_rsp_data through.

Decomposition:
- def.sv gets:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_REQ, ARB_RSP}
  - owner encodings OWN_IF = 1'b0, OWN_D = 1'b1
- Sub-module arb_pick contains the combinational winner selection plus the saturating fetch wait counter.
  - Inputs: clk, rst, state_is_idle, if_valid, d_valid.
  - Outputs: grant_if, grant_d.
- mem_arb holds the FSM, latches and response routing.

Test Plan:
- IF only, zero-wait memory:
  - Stimulus: if_req_valid at cycle 1, addr 0x100; memory returns 0xDEADBEEF.
  - Response: if_req_ready at cycle 1; mem_req_valid at cycle 2 with addr 0x100, wen 0; if_rsp_valid at cycle 3 with data 0xDEADBEEF; d_rsp_valid stays 0.
- D store with memory stalls:
  - Stimulus: addr 0x200, wdata 0x12345678, wstrb 4'b0011; mem_req_ready held low 3 cycles; response 2 cycles after accept.
  - Response: mem_req fields stable through the stall; exactly one d_rsp_valid pulse; busy high throughout.
- Simultaneous requests:
  - Stimulus: both valid continuously, MAX_WAIT=4.
  - Response: grant order D, D, D, D, IF, D, D, D, D, IF.
  - Counter reads 4 before each IF grant and 0 after it.
- IF drops valid while losing:
  - Stimulus: if_req_valid low for 2 cycles in the middle of the contention.
  - Response: the counter holds its value and does not reset.
- Stray response and reset:
  - Stray response: mem_rsp_valid pulsed in ARB_IDLE produces no rsp strobes.
  - Reset: rst low during ARB_REQ; after the edge mem_req_valid=0, busy=0, state ARB_IDLE, and no response is delivered for that transaction.
- Back-to-back:
  - Stimulus: a D load followed immediately by a D load.
  - Response: the second d_req_ready is asserted no earlier than the cycle after the first d_rsp_valid.
